// File: rtl/des_sbox_layer_seq_if.sv
// Handshake bundle for the DES S-box layer: upstream word in, 32-bit result out.
interface des_sbox_layer_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_sbox_layer_seq.sv
// Sequential DES S-box layer, LANES S-boxes per cycle over 8/LANES passes.
// Define DES_SBOX_PBOX_EN to present the P-permuted result on out_data.
//
// state   | meaning
// IDLE    | waiting for a word, in_ready high
// COMPUTE | LANES S-boxes evaluated per cycle, busy high
// DONE    | result held on out_data until out_ready
module des_sbox_layer_seq #(
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    des_sbox_layer_seq_if.slave  bus,
    output logic                 busy
);
    localparam int PASSES = 8 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("des_sbox_layer_seq: LANES must be 1, 2, 4 or 8");
    end

    // Each table is 64 nibbles, row-major (row 0 col 0 in the top nibble).
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox(input logic [2:0] k, input logic [5:0] c);
        logic [5:0] addr;
        addr = {c[5], c[0], c[4:1]};
        return SB[k][4*(63 - int'(addr)) +: 4];
    endfunction

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [47:0]     cap;
    logic [31:0]     res;
    logic            load;
    logic [2:0]      lane_sel [LANES];
    logic [3:0]      lane_nib [LANES];

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy         = 1'b0;
        load         = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (cnt == CW'(PASSES - 1)) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    load      = bus.in_valid;
                    state_nxt = bus.in_valid ? COMPUTE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing may be accepted during a reset cycle.
        if (rst) bus.in_ready = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_sel[i] = 3'(int'(cnt) * LANES + i);
            lane_nib[i] = sbox(lane_sel[i], cap[6*(7 - int'(lane_sel[i])) +: 6]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cap <= bus.in_data;
                cnt <= '0;
            end else if (state == COMPUTE) begin
                cnt <= (cnt == CW'(PASSES - 1)) ? '0 : cnt + 1'b1;
                for (int i = 0; i < LANES; i++)
                    res[4*(7 - int'(lane_sel[i])) +: 4] <= lane_nib[i];
            end
        end
    end

`ifdef DES_SBOX_PBOX_EN
    localparam int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    logic [31:0] perm;
    always_comb begin
        perm = '0;
        for (int i = 0; i < 32; i++) perm[31 - i] = res[32 - PT[i]];
    end
    assign bus.out_data = perm;
`else
    assign bus.out_data = res;
`endif

endmodule

// File: tb/tb_des_sbox_layer_seq.sv
// Bench for des_sbox_layer_seq: one instance per legal LANES value, table vectors,
// hand-written corner sequences and a randomized stream against a table model.
module tb_des_sbox_layer_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid  = '0;
    logic [3:0]  out_ready = '0;
    logic [47:0] in_data [4];
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  busy;
    logic [31:0] out_data [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_layer_seq_if ifc ();
        assign ifc.in_valid  = in_valid[g];
        assign ifc.in_data   = in_data[g];
        assign ifc.out_ready = out_ready[g];
        assign in_ready[g]   = ifc.in_ready;
        assign out_valid[g]  = ifc.out_valid;
        assign out_data[g]   = ifc.out_data;
        des_sbox_layer_seq #(.LANES(1 << g)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (ifc),
            .busy (busy[g])
        );
    end

    localparam int ST [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };
    localparam int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    function automatic logic [31:0] pbox_if_en(input logic [31:0] s);
        logic [31:0] p;
        p = s;
`ifdef DES_SBOX_PBOX_EN
        p = '0;
        for (int i = 1; i <= 32; i++) p[32 - i] = s[32 - PT[i - 1]];
`endif
        return p;
    endfunction

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] s;
        int c, row, col;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            c   = int'((d >> (42 - 6 * k)) & 48'h3f);
            row = (c >> 5) * 2 + (c & 1);
            col = (c >> 1) & 15;
            s   = s | (32'(ST[k][row][col]) << (28 - 4 * k));
        end
        return pbox_if_en(s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word, wait for its result, check data and latency, then accept it.
    task automatic run_word(input int g, input logic [47:0] d, input logic [31:0] e,
                            input int lat_exp, input string name);
        int lat;
        check({name, "_in_ready"}, 64'(in_ready[g]), 64'd1);
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        tick();
        in_valid[g] = 1'b0;
        in_data[g]  = ~d;
        check({name, "_busy"}, 64'(busy[g]), 64'd1);
        lat = 0;
        do begin
            if (!out_valid[g]) begin
                tick();
                lat++;
            end
        end while (!out_valid[g] && lat < 20);
        check({name, "_latency"}, 64'(lat), 64'(lat_exp));
        check({name, "_data"}, 64'(out_data[g]), 64'(e));
        check({name, "_busy_done"}, 64'(busy[g]), 64'd0);
        out_ready[g] = 1'b1;
        tick();
        out_ready[g] = 1'b0;
        check({name, "_released"}, {62'd0, out_valid[g], in_ready[g]}, 64'b01);
    endtask

    typedef struct {
        int          g;
        logic [47:0] d;
        logic [31:0] e;
        int          lat;
    } vec_t;

`ifdef DES_SBOX_PBOX_EN
    localparam logic [31:0] E_ZERO = 32'hD8D8DBBC;
`else
    localparam logic [31:0] E_ZERO = 32'hEFA72C4D;
`endif

    initial begin
        vec_t        vecs [$];
        logic [31:0] e_ones;
        int          lat;
        logic        seen;

        for (int g = 0; g < 4; g++) in_data[g] = '0;
        e_ones = pbox_if_en(32'hD9CE3DCB);
        for (int g = 0; g < 4; g++) begin
            vecs.push_back('{g, 48'h000000000000, E_ZERO, 8 >> g});
            vecs.push_back('{g, 48'hFFFFFFFFFFFF, e_ones, 8 >> g});
        end

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) tick();
        check("reset_hold", {in_ready, out_valid, busy}, 64'd0);
        for (int g = 0; g < 4; g++) check("reset_out_data", 64'(out_data[g]), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_release_in_ready", 64'(in_ready), 64'hF);

        foreach (vecs[i]) run_word(vecs[i].g, vecs[i].d, vecs[i].e, vecs[i].lat, "vec");

        // LANES=1: result stalled in DONE, then back-to-back acceptance.
        in_valid[0] = 1'b1;
        in_data[0]  = 48'h0;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("stall_latency", 64'(lat), 64'd8);
        for (int c = 0; c < 5; c++) begin
            check("stall_hold", {out_valid[0], in_ready[0], 30'd0, out_data[0]},
                  {1'b1, 1'b0, 30'd0, E_ZERO});
            tick();
        end
        in_valid[0]  = 1'b1;
        in_data[0]   = 48'hFFFFFFFFFFFF;
        out_ready[0] = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready[0]), 64'd1);
        tick();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check("b2b_busy", 64'(busy[0]), 64'd1);
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_latency", 64'(lat), 64'd8);
        check("b2b_data", 64'(out_data[0]), 64'(e_ones));
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // LANES=1: reset during pass 3 discards the word.
        in_valid[0] = 1'b1;
        in_data[0]  = 48'hFFFFFFFFFFFF;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midreset_state", {in_ready[0], out_valid[0], busy[0]}, 64'b100);
        check("midreset_out_data", 64'(out_data[0]), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | out_valid[0];
        end
        check("midreset_no_output", 64'(seen), 64'd0);
        run_word(0, 48'h0, E_ZERO, 8, "after_reset");

        // Randomized stream with random stalls on both sides.
        for (int g = 0; g < 4; g++) begin
            logic [31:0] exp_q [$];
            logic [47:0] pdata;
            logic [63:0] r;
            logic        pend;
            int          sent, got, cyc;
            pend = 1'b0;
            pdata = '0;
            sent = 0;
            got = 0;
            cyc = 0;
            while (got < 1000 && cyc < 40000) begin
                if (!pend && sent < 1000 && $urandom_range(3) != 0) begin
                    r     = {$urandom, $urandom};
                    pdata = r[47:0];
                    pend  = 1'b1;
                end
                r            = {$urandom, $urandom};
                in_valid[g]  = pend;
                in_data[g]   = pend ? pdata : r[47:0];
                out_ready[g] = ($urandom_range(3) != 0);
                #1;
                if (in_valid[g] && in_ready[g]) begin
                    exp_q.push_back(model(pdata));
                    pend = 1'b0;
                    sent++;
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q.size() == 0) check("rand_unexpected_output", 64'd1, 64'd0);
                    else check("rand_data", 64'(out_data[g]), 64'(exp_q.pop_front()));
                    got++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            check("rand_count", 64'(got), 64'd1000);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
